// File: rtl/uart_rx_dev_pkg.sv
// Shared constants for the memory-mapped UART receiver.
// Register offsets, FSM state encodings and status register bit positions.
package uart_rx_dev_pkg;

  localparam logic [3:0] UART_RX_DATA = 4'h4;
  localparam logic [3:0] UART_RX_STAT = 4'h5;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE  = 3'd0;
  localparam rx_state_t RX_START = 3'd1;
  localparam rx_state_t RX_DATA  = 3'd2;
  localparam rx_state_t RX_STOP  = 3'd3;
  localparam rx_state_t RX_BREAK = 3'd4;

  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int STAT_COUNT_LSB = 4;

endpackage

// File: rtl/uart_rx_dev_if.sv
// CPU bus request signals seen by the UART receiver.
//   en           : I/O window select (addr[29])
//   rd_en        : CPU load in progress this cycle
//   write_enable : store strobes, [2] = byte store
//   addr         : bus address, low nibble decoded
//   data_in      : store data
// Read data stays a plain tri-state port on the device.
interface uart_rx_dev_if;
  logic        en;
  logic        rd_en;
  logic [2:0]  write_enable;
  logic [31:0] addr;
  logic [31:0] data_in;

  modport master (output en, rd_en, write_enable, addr, data_in);
  modport slave  (input  en, rd_en, write_enable, addr, data_in);
endinterface

// File: rtl/uart_rx_dev_sync_fifo.sv
// Small synchronous FIFO for received bytes.
//   push/din   : write request and data (dropped when full unless popping)
//   pop/dout   : read request and head entry
//   full/empty : occupancy flags
//   count      : number of stored entries
module sync_fifo
  import uart_rx_dev_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_dev.sv
// Memory-mapped 8N1 UART receiver with 16x oversampling and a receive FIFO.
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : CPU request side (en, rd_en, write_enable, addr, data_in)
//   uart_rxd  : asynchronous serial input, idle high
//   data_out  : read data, tri-stated unless offset 0x4 (data) / 0x5 (status)
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | checking the start bit at its middle
// DATA  | sampling eight data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | framing error seen, waiting for the line to return high
module uart_rx_dev
  import uart_rx_dev_pkg::*;
#(
  parameter int DIVISOR    = 78,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_dev_if.slave  bus,
  input  logic          uart_rxd,
  output wire  [31:0]   data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic            rx_meta;
  logic            rx_s;
  rx_state_t       state;
  logic [15:0]     tick_cnt;
  logic            tick;
  logic [3:0]      samp_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            start_edge;
  logic            stop_sample;
  logic            push;
  logic            pop;
  logic            frame_err;
  logic            overrun;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  logic [4:0]      count_ext;
  logic [3:0]      offset;
  logic            sel_data;
  logic            sel_stat;
  logic            stat_wr;
  logic [31:0]     rd_data;
  logic            unused_bus_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_s    <= rx_meta;
    end
  end

  assign tick       = (tick_cnt == 16'(DIVISOR - 1));
  assign start_edge = (state == RX_IDLE) && !rx_s;

  // Restarting the divider on the start edge puts every 16th tick mid-bit.
  always_ff @(posedge clk) begin
    if (rst || start_edge || tick) tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + 16'd1;
  end

  assign stop_sample = (state == RX_STOP) && tick && (samp_cnt == 4'd15);
  assign push        = stop_sample && rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
            state    <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (samp_cnt == 4'd7) begin
              samp_cnt <= '0;
              state    <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (samp_cnt == 4'd15) begin
              shift_reg <= {rx_s, shift_reg[7:1]};
              samp_cnt  <= '0;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RX_STOP;
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (samp_cnt == 4'd15) state <= rx_s ? RX_IDLE : RX_BREAK;
            else                   samp_cnt <= samp_cnt + 4'd1;
          end
        end
        RX_BREAK: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign offset   = bus.addr[3:0];
  assign sel_data = bus.en && (offset == UART_RX_DATA);
  assign sel_stat = bus.en && (offset == UART_RX_STAT);
  assign pop      = sel_data && bus.rd_en && !fifo_empty;
  assign stat_wr  = bus.en && bus.write_enable[2] && (offset == UART_RX_STAT);

  // Write-1-to-clear; a set in the same cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (push && fifo_full && !pop) ||
                   (overrun && !(stat_wr && bus.data_in[STAT_OVERRUN]));
      frame_err <= (stop_sample && !rx_s) ||
                   (frame_err && !(stat_wr && bus.data_in[STAT_FRAME_ERR]));
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (shift_reg),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign count_ext = 5'(fifo_count);

  always_comb begin
    rd_data = '0;
    if (sel_data) begin
      rd_data[7:0] = fifo_empty ? 8'h00 : fifo_dout;
    end else begin
      rd_data[STAT_COUNT_LSB +: 4] = count_ext[3:0];
      rd_data[STAT_FRAME_ERR]      = frame_err;
      rd_data[STAT_OVERRUN]        = overrun;
      rd_data[STAT_NONEMPTY]       = !fifo_empty;
    end
  end

  assign data_out = (sel_data || sel_stat) ? rd_data : 32'hzzzz_zzzz;

  assign unused_bus_bits = ^{bus.addr[31:4], bus.data_in[31:3], bus.data_in[0],
                             bus.write_enable[1:0], count_ext[4]};

endmodule
